vend_change_dispenser: RTL and testbench

VEND_CHANGE_DISPENSER -- requirements
Module: vend_change_dispenser

---
 rtl/vend_change_dispenser_pkg.sv | 26 ++
 rtl/vend_change_dispenser_if.sv | 35 +++
 rtl/vend_change_dispenser_coin_select.sv | 25 ++
 rtl/vend_change_dispenser.sv | 122 ++++++++++++
 tb/tb_vend_change_dispenser.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vend_change_dispenser_pkg.sv
// Shared denomination codes, unit values and FSM encoding for the change dispenser.
// Inventory tracking is compiled in only when VEND_INVENTORY_EN is defined.
package vend_pkg;

  typedef enum logic [1:0] {
    FIVE    = 2'b00,
    TEN     = 2'b01,
    FIFTEEN = 2'b10,
    TWENTY  = 2'b11
  } coin_e;

  localparam int unsigned NUM_DENOM = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SELECT = 2'b01,
    ISSUE  = 2'b10,
    DONE   = 2'b11
  } state_e;

  // Codes are ordered so that value in 5-rupee units is code+1.
  function automatic logic [2:0] coin_units(input coin_e c);
    return {1'b0, c} + 3'd1;
  endfunction

endpackage

// File: rtl/vend_change_dispenser_if.sv
// Request/hopper bundle between the vending FSM (master) and the change dispenser (slave).
// refill/short are present only when VEND_INVENTORY_EN is defined.
interface vend_change_dispenser_if #(
  parameter int unsigned AMT_W = 5
);
  logic             req;
  logic [AMT_W-1:0] amount;
  logic             ready;
  logic             coin_valid;
  logic [1:0]       coin;
  logic             coin_ack;
  logic             done;
`ifdef VEND_INVENTORY_EN
  logic             refill;
  logic             short;

  modport master (
    output req, amount, coin_ack, refill,
    input  ready, coin_valid, coin, done, short
  );
  modport slave (
    input  req, amount, coin_ack, refill,
    output ready, coin_valid, coin, done, short
  );
`else
  modport master (
    output req, amount, coin_ack,
    input  ready, coin_valid, coin, done
  );
  modport slave (
    input  req, amount, coin_ack,
    output ready, coin_valid, coin, done
  );
`endif
endinterface

// File: rtl/vend_change_dispenser_coin_select.sv
// Combinational greedy picker: largest available denomination not exceeding the remainder.
module vend_coin_select
  import vend_pkg::*;
#(
  parameter int unsigned AMT_W = 5
) (
  input  logic [AMT_W-1:0]     rem_i,
  input  logic [NUM_DENOM-1:0] avail_i,
  output coin_e                code_o,
  output logic                 found_o
);

  // Ascending scan; a later (larger) fitting coin overrides a smaller one.
  always_comb begin
    code_o  = FIVE;
    found_o = 1'b0;
    for (int unsigned i = 0; i < NUM_DENOM; i++) begin
      if (avail_i[i] && (rem_i >= AMT_W'(coin_units(coin_e'(i[1:0]))))) begin
        code_o  = coin_e'(i[1:0]);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vend_change_dispenser.sv
// Change dispenser: pays out a remainder coin by coin to a hopper using a greedy pick.
// Define VEND_INVENTORY_EN to add per-denomination coin counters, refill and short.
module vend_change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned AMT_W    = 5,
  parameter int unsigned INV_INIT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  vend_change_dispenser_if.slave  bus
);

  state_e               state_q, state_d;
  logic [AMT_W-1:0]     rem_q, rem_d;
  coin_e                coin_q, coin_d;
  logic [NUM_DENOM-1:0] avail;
  coin_e                pick;
  logic                 found;

  vend_coin_select #(.AMT_W(AMT_W)) u_select (
    .rem_i   (rem_q),
    .avail_i (avail),
    .code_o  (pick),
    .found_o (found)
  );

`ifdef VEND_INVENTORY_EN
  localparam int unsigned CNT_W = $clog2(INV_INIT + 1);

  logic [CNT_W-1:0] cnt_q [NUM_DENOM];
  logic             short_q, short_d;
  logic             xfer;

  assign xfer = (state_q == ISSUE) && bus.coin_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_DENOM; i++) cnt_q[i] <= CNT_W'(INV_INIT);
    end else if (bus.refill) begin
      for (int unsigned i = 0; i < NUM_DENOM; i++) cnt_q[i] <= CNT_W'(INV_INIT);
    end else if (xfer) begin
      cnt_q[coin_q] <= cnt_q[coin_q] - CNT_W'(1);
    end
  end

  always_comb begin
    avail = '0;
    for (int unsigned i = 0; i < NUM_DENOM; i++) avail[i] = (cnt_q[i] != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) short_q <= 1'b0;
    else      short_q <= short_d;
  end

  assign bus.short = short_q;
`else
  assign avail = '1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      coin_q  <= FIVE;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      coin_q  <= coin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    coin_d  = coin_q;
`ifdef VEND_INVENTORY_EN
    short_d = short_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          rem_d   = bus.amount;
          state_d = (bus.amount != '0) ? SELECT : DONE;
        end
      end
      SELECT: begin
        if (found) begin
          coin_d  = pick;
          state_d = ISSUE;
        end else begin
          // Nothing payable remains in stock: abandon the remainder.
          rem_d   = '0;
          state_d = DONE;
`ifdef VEND_INVENTORY_EN
          short_d = 1'b1;
`endif
        end
      end
      ISSUE: begin
        if (bus.coin_ack) begin
          rem_d   = rem_q - AMT_W'(coin_units(coin_q));
          state_d = (rem_d != '0) ? SELECT : DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef VEND_INVENTORY_EN
        short_d = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ready      = (state_q == IDLE);
  assign bus.coin_valid = (state_q == ISSUE);
  assign bus.coin       = coin_q;
  assign bus.done       = (state_q == DONE);

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Self-checking bench for vend_change_dispenser: vector table plus hand-written corner sequences,
// with a scoreboard of expected coins and done pulses. Inventory tests need VEND_INVENTORY_EN.
module tb_vend_change_dispenser;
  import vend_pkg::*;

  localparam int unsigned AMT_W    = 5;
  localparam int unsigned INV_INIT = 15;
  localparam int unsigned NVEC     = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vend_change_dispenser_if #(.AMT_W(AMT_W)) bus ();

  vend_change_dispenser #(.AMT_W(AMT_W), .INV_INIT(INV_INIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // seq holds coin k in bits [2k+1:2k].
  typedef struct {
    logic [AMT_W-1:0] amount;
    int unsigned      n;
    logic [15:0]      seq;
  } vec_t;

  vec_t       vecs [NVEC];
  logic [1:0] exp_q  [$];
  bit         done_q [$];
  int         total = 0;
  int         bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: transfers and done pulses observed mid-cycle.
  always @(negedge clk) begin
    if (rst && bus.coin_valid && bus.coin_ack) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_coin: got coin %0d expected none", bus.coin);
      end else begin
        total--;
        check("coin", {30'd0, bus.coin}, {30'd0, exp_q.pop_front()});
      end
    end
    if (rst && bus.done) begin
      total++;
      if (done_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: got done=1 expected none");
      end else begin
        total--;
        check("coins_left_at_done", exp_q.size(), 0);
`ifdef VEND_INVENTORY_EN
        check("short", {31'd0, bus.short}, {31'd0, done_q.pop_front()});
`else
        void'(done_q.pop_front());
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [AMT_W-1:0] a);
    bus.req    = 1'b1;
    bus.amount = a;
    tick();
    bus.req    = 1'b0;
  endtask

  task automatic push_n(input logic [1:0] c, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) exp_q.push_back(c);
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int unsigned k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s_timeout: got no done expected done within 200 cycles", name);
    end
    @(negedge clk);
    check({name, "_ready"}, {31'd0, bus.ready}, 32'd1);
    tick();
  endtask

`ifdef VEND_INVENTORY_EN
  task automatic do_refill();
    bus.refill = 1'b1;
    tick();
    bus.refill = 1'b0;
  endtask

  task automatic job(input logic [AMT_W-1:0] a, input logic [1:0] c, input int unsigned n,
                     input bit sh, input string name);
    push_n(c, n);
    done_q.push_back(sh);
    start(a);
    wait_done(name);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100us");
    $fatal(1);
  end

  initial begin
    logic [7:0] cv_pat, done_pat, rdy_pat;

    vecs[0] = '{amount: 5'd9,  n: 3, seq: 16'h000F};
    vecs[1] = '{amount: 5'd0,  n: 0, seq: 16'h0000};
    vecs[2] = '{amount: 5'd1,  n: 1, seq: 16'h0000};
    vecs[3] = '{amount: 5'd2,  n: 1, seq: 16'h0001};
    vecs[4] = '{amount: 5'd3,  n: 1, seq: 16'h0002};
    vecs[5] = '{amount: 5'd4,  n: 1, seq: 16'h0003};
    vecs[6] = '{amount: 5'd6,  n: 2, seq: 16'h0007};
    vecs[7] = '{amount: 5'd7,  n: 2, seq: 16'h000B};
    vecs[8] = '{amount: 5'd13, n: 4, seq: 16'h003F};
    vecs[9] = '{amount: 5'd31, n: 8, seq: 16'hBFFF};

    rst          = 1'b0;
    bus.req      = 1'b0;
    bus.amount   = '0;
    bus.coin_ack = 1'b1;
`ifdef VEND_INVENTORY_EN
    bus.refill   = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, bus.ready}, 32'd1);
    check("rst_coin_valid", {31'd0, bus.coin_valid}, 32'd0);
    check("rst_coin", {30'd0, bus.coin}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
`ifdef VEND_INVENTORY_EN
    check("rst_short", {31'd0, bus.short}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    tick();

    for (int i = 0; i < NVEC; i++) begin
`ifdef VEND_INVENTORY_EN
      do_refill();
`endif
      for (int unsigned k = 0; k < vecs[i].n; k++) exp_q.push_back(vecs[i].seq[2*k +: 2]);
      done_q.push_back(1'b0);
      start(vecs[i].amount);
      wait_done($sformatf("vec%0d", i));
    end

    // amount=9, ack high: exact cycle pattern after the sampling edge.
    push_n(TWENTY, 2);
    push_n(FIVE, 1);
    done_q.push_back(1'b0);
    cv_pat   = 8'b0010_1010;
    done_pat = 8'b0100_0000;
    rdy_pat  = 8'b1000_0000;
    start(5'd9);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      check($sformatf("a9_cv%0d", j), {31'd0, bus.coin_valid}, {31'd0, cv_pat[j]});
      check($sformatf("a9_done%0d", j), {31'd0, bus.done}, {31'd0, done_pat[j]});
      check($sformatf("a9_ready%0d", j), {31'd0, bus.ready}, {31'd0, rdy_pat[j]});
    end
    tick();

    // amount=0: straight to done, no coin.
    done_q.push_back(1'b0);
    start(5'd0);
    @(negedge clk);
    check("a0_cv", {31'd0, bus.coin_valid}, 32'd0);
    check("a0_done", {31'd0, bus.done}, 32'd1);
    @(negedge clk);
    check("a0_done_off", {31'd0, bus.done}, 32'd0);
    check("a0_ready", {31'd0, bus.ready}, 32'd1);
    tick();

    // amount=3 with the hopper stalling; a stray req mid-job must be ignored.
    bus.coin_ack = 1'b0;
    push_n(FIFTEEN, 1);
    done_q.push_back(1'b0);
    start(5'd3);
    @(negedge clk);
    check("a3_select_cv", {31'd0, bus.coin_valid}, 32'd0);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check($sformatf("a3_hold_cv%0d", j), {31'd0, bus.coin_valid}, 32'd1);
      check($sformatf("a3_hold_coin%0d", j), {30'd0, bus.coin}, 32'd2);
      bus.req    = (j == 0);
      bus.amount = 5'd5;
    end
    bus.req = 1'b0;
    @(posedge clk);
    #1;
    bus.coin_ack = 1'b1;
    @(negedge clk);
    check("a3_ack_cv", {31'd0, bus.coin_valid}, 32'd1);
    @(negedge clk);
    check("a3_done", {31'd0, bus.done}, 32'd1);
    @(negedge clk);
    check("a3_ready", {31'd0, bus.ready}, 32'd1);
    tick();

    // Reset while in ISSUE aborts the job with no coin afterwards.
    bus.coin_ack = 1'b0;
    start(5'd9);
    @(negedge clk);
    @(negedge clk);
    check("mid_in_issue", {31'd0, bus.coin_valid}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_cv", {31'd0, bus.coin_valid}, 32'd0);
    check("mid_rst_coin", {30'd0, bus.coin}, 32'd0);
    check("mid_rst_done", {31'd0, bus.done}, 32'd0);
    check("mid_rst_ready", {31'd0, bus.ready}, 32'd1);
`ifdef VEND_INVENTORY_EN
    check("mid_rst_short", {31'd0, bus.short}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    bus.coin_ack = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check($sformatf("post_rst_cv%0d", j), {31'd0, bus.coin_valid}, 32'd0);
      check($sformatf("post_rst_ready%0d", j), {31'd0, bus.ready}, 32'd1);
    end
    tick();

`ifdef VEND_INVENTORY_EN
    // Leave one TWENTY, then 8 must pay TWENTY, FIFTEEN, FIVE.
    do_refill();
    job(5'd28, TWENTY, 7, 1'b0, "drain_t1");
    job(5'd28, TWENTY, 7, 1'b0, "drain_t2");
    push_n(TWENTY, 1);
    push_n(FIFTEEN, 1);
    push_n(FIVE, 1);
    done_q.push_back(1'b0);
    start(5'd8);
    wait_done("inv_a8");

    // Empty every denomination, then amount=2 must short with no coins.
    do_refill();
    job(5'd28, TWENTY, 7, 1'b0, "z_t1");
    job(5'd28, TWENTY, 7, 1'b0, "z_t2");
    job(5'd4,  TWENTY, 1, 1'b0, "z_t3");
    job(5'd30, FIFTEEN, 10, 1'b0, "z_f1");
    job(5'd15, FIFTEEN, 5, 1'b0, "z_f2");
    job(5'd30, TEN, 15, 1'b0, "z_ten");
    job(5'd15, FIVE, 15, 1'b0, "z_five");
    job(5'd2,  FIVE, 0, 1'b1, "z_short");
`endif

    check("leftover_coins", exp_q.size(), 0);
    check("leftover_dones", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
